// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types, opcodes and per-state control decode for the multicycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_J = 2'b10,
        IMM_B = 2'b11
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEM    = 2'b01,
        RES_ALU    = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // fetch and branch are qualifiers: their strobes also need mem_ready or zero
    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        fetch;
        logic        branch;
        logic        pc_write;
        logic        reg_write;
        result_src_t result_src;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_JAL:    return IMM_J;
            OP_BRANCH: return IMM_B;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALU operation decode from alu_op and instruction funct fields
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t     i_alu_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic        i_op_5,
    output alu_ctrl_t   o_alu_ctrl,
    output logic        o_funct_illegal
);

    always_comb begin
        o_alu_ctrl      = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_SUB: o_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // only R-type carries a sub variant; addi ignores bit 30
                    3'b000:  o_alu_ctrl = (i_op_5 && i_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_ctrl = ALU_SLT;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    3'b111:  o_alu_ctrl = ALU_AND;
                    default: o_funct_illegal = 1'b1;
                endcase
            end
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multicycle RV32I core
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       imm_src,
    output logic             illegal_instr,
    output logic [3:0]       state_o
);

    state_t    r_state;
    state_t    w_next_state;
    ctrl_t     r_ctrl;
    logic      r_kill_wb;
    logic [6:0] w_op;
    logic      w_exec;
    logic      w_decode_illegal;
    alu_ctrl_t w_alu_ctrl;
    logic      w_funct_illegal;
    logic      w_unused;

    assign w_op     = instr[6:0];
    assign w_exec   = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
    assign w_unused = ^{instr[WIDTH-1:31], instr[29:15], instr[11:7]};
    assign w_decode_illegal = (r_state == S_DECODE) && !op_supported(w_op);

    alu_decoder u_alu_decoder (
        .i_alu_op        (r_ctrl.alu_op),
        .i_funct3        (instr[14:12]),
        .i_funct7_5      (instr[30]),
        .i_op_5          (instr[5]),
        .o_alu_ctrl      (w_alu_ctrl),
        .o_funct_illegal (w_funct_illegal)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_R:              w_next_state = S_EXECUTER;
                    OP_I:              w_next_state = S_EXECUTEI;
                    OP_BRANCH:         w_next_state = S_BEQ;
                    OP_JAL:            w_next_state = S_JAL;
                    default:           w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = w_op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXECUTER, S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= state_ctrl(S_FETCH);
            r_kill_wb <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ctrl    <= state_ctrl(w_next_state);
            r_kill_wb <= w_exec && w_funct_illegal;
        end
    end

    // Strobes are gated by rst_n so reset silences them without waiting for a clock
    assign mem_req       = rst_n & r_ctrl.mem_req;
    assign mem_write     = rst_n & r_ctrl.mem_write;
    assign ir_write      = rst_n & r_ctrl.fetch & mem_ready;
    assign pc_write      = rst_n & ((r_ctrl.fetch & mem_ready) | (r_ctrl.branch & zero) | r_ctrl.pc_write);
    assign reg_write     = rst_n & r_ctrl.reg_write & ~r_kill_wb;
    assign illegal_instr = rst_n & (w_decode_illegal | (w_exec & w_funct_illegal));

    assign adr_src    = r_ctrl.adr_src;
    assign result_src = r_ctrl.result_src;
    assign alu_src_a  = r_ctrl.alu_src_a;
    assign alu_src_b  = r_ctrl.alu_src_b;
    assign alu_ctrl   = w_alu_ctrl;
    assign imm_src    = imm_src_of(w_op);
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized scoreboard bench for multicycle_controller
module tb_multicycle_controller;
    import riscv_ctrl_pkg::S_FETCH;

    localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
    localparam logic [6:0] T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero, mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_ctrl;
    logic [3:0]  state_o;

    typedef struct {
        string      tag;
        bit         mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
        bit [1:0]   result_src, alu_a, alu_b, imm;
        bit [2:0]   alu;
        bit         alu_care, chk_state;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cur;

    multicycle_controller #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .illegal_instr(illegal_instr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit supported(input logic [6:0] op);
        return op == T_LOAD || op == T_STORE || op == T_R || op == T_I || op == T_BR || op == T_JAL;
    endfunction

    function automatic bit [1:0] imm_of(input logic [6:0] op);
        if (op == T_STORE) return 2'b01;
        if (op == T_JAL)   return 2'b10;
        if (op == T_BR)    return 2'b11;
        return 2'b00;
    endfunction

    function automatic void alu_exp(input logic [31:0] w, output bit [2:0] code, output bit bad);
        bad  = 1'b0;
        code = 3'b000;
        case (w[14:12])
            3'b000:  code = (w[5] && w[30]) ? 3'b001 : 3'b000;
            3'b010:  code = 3'b101;
            3'b110:  code = 3'b011;
            3'b111:  code = 3'b010;
            default: bad = 1'b1;
        endcase
    endfunction

    function automatic exp_t base(input string phase);
        exp_t e;
        e.tag = $sformatf("%s@%08h", phase, cur);
        e.mem_req = 0; e.mem_write = 0; e.adr_src = 0; e.ir_write = 0; e.pc_write = 0;
        e.reg_write = 0; e.illegal = 0; e.result_src = 0; e.alu_a = 0; e.alu_b = 0;
        e.alu = 0; e.alu_care = 1; e.chk_state = 0;
        e.imm = imm_of(cur[6:0]);
        return e;
    endfunction

    task automatic cyc(input exp_t e, input bit rdy, input bit z);
        mem_ready = rdy;
        zero = z;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = base("RESET");
            e.alu_b = 2'b10; e.result_src = 2'b10; e.chk_state = 1;
            cyc(e, rb(), rb());
        end
        rst_n = 1'b1;
    endtask

    task automatic run(input logic [31:0] w, input int fw, input int mw, input bit z, input int abort_at);
        exp_t e;
        bit [2:0] ac;
        bit bad;
        for (int i = 0; i <= fw; i++) begin
            e = base("FETCH");
            e.mem_req = 1; e.alu_b = 2'b10; e.result_src = 2'b10; e.chk_state = 1;
            e.ir_write = (i == fw); e.pc_write = (i == fw);
            cyc(e, i == fw, rb());
        end
        instr = w;
        cur = w;
        e = base("DECODE");
        e.alu_a = 2'b01; e.alu_b = 2'b01; e.illegal = !supported(w[6:0]);
        cyc(e, rb(), rb());
        if (w[6:0] == T_LOAD || w[6:0] == T_STORE) begin
            e = base("MEMADR");
            e.alu_a = 2'b10; e.alu_b = 2'b01;
            cyc(e, rb(), rb());
            for (int i = 0; i <= mw; i++) begin
                if (w[6:0] == T_STORE && i == abort_at) begin
                    reset_cycles(2);
                    return;
                end
                e = base(w[6:0] == T_LOAD ? "MEMREAD" : "MEMWRITE");
                e.mem_req = 1; e.adr_src = 1; e.mem_write = (w[6:0] == T_STORE);
                cyc(e, i == mw, rb());
            end
            if (w[6:0] == T_LOAD) begin
                e = base("MEMWB");
                e.result_src = 2'b01; e.reg_write = 1;
                cyc(e, rb(), rb());
            end
        end else if (w[6:0] == T_R || w[6:0] == T_I) begin
            alu_exp(w, ac, bad);
            e = base("EXEC");
            e.alu_a = 2'b10; e.alu_b = (w[6:0] == T_I) ? 2'b01 : 2'b00;
            e.alu = ac; e.alu_care = !bad; e.illegal = bad;
            cyc(e, rb(), rb());
            e = base("ALUWB");
            e.reg_write = !bad;
            cyc(e, rb(), rb());
        end else if (w[6:0] == T_BR) begin
            e = base("BEQ");
            e.alu_a = 2'b10; e.alu = 3'b001; e.pc_write = z;
            cyc(e, rb(), z);
        end else if (w[6:0] == T_JAL) begin
            e = base("JAL");
            e.alu_a = 2'b01; e.alu_b = 2'b10; e.pc_write = 1;
            cyc(e, rb(), rb());
            e = base("ALUWB");
            e.reg_write = 1;
            cyc(e, rb(), rb());
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: op = T_LOAD;
            1: op = T_STORE;
            2: op = T_R;
            3: op = T_I;
            4: op = T_BR;
            5: op = T_JAL;
            default: begin
                op = 7'($urandom_range(0, 127));
                while (supported(op)) op = 7'($urandom_range(0, 127));
            end
        endcase
        w[6:0] = op;
        return w;
    endfunction

    initial begin : monitor
        exp_t e;
        logic [17:0] act, expv;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act  = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr,
                        result_src, alu_src_a, alu_src_b, (e.alu_care ? alu_ctrl : 3'b000), imm_src};
                expv = {e.mem_req, e.mem_write, e.adr_src, e.ir_write, e.pc_write, e.reg_write, e.illegal,
                        e.result_src, e.alu_a, e.alu_b, e.alu, e.imm};
                checks++;
                if (act !== expv) begin
                    failures++;
                    $display("FAIL ctrl %s: got=%05h expected=%05h", e.tag, act, expv);
                end
                if (e.chk_state) begin
                    checks++;
                    if (state_o !== 4'(S_FETCH)) begin
                        failures++;
                        $display("FAIL state %s: got=%0d expected=%0d", e.tag, state_o, 4'(S_FETCH));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d expected=0", sb.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b1; instr = '0; cur = '0; zero = 0; mem_ready = 0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        reset_cycles(2);
        run(32'h002081B3, 0, 0, 0, -1);
        run(32'h0080A283, 0, 3, 0, -1);
        run(32'h00208463, 0, 0, 1, -1);
        run(32'h00208463, 1, 0, 0, -1);
        run(32'h010000EF, 0, 0, 0, -1);
        run(32'h0000007F, 0, 0, 0, -1);
        run(32'h402081B3, 0, 0, 0, -1);
        run(32'h0050A093, 2, 0, 0, -1);
        run(32'h0020E1B3, 0, 0, 0, -1);
        run(32'h0020F1B3, 0, 0, 0, -1);
        run(32'h002091B3, 0, 0, 0, -1);
        run(32'h00112423, 0, 2, 0, -1);
        run(32'h00112423, 0, 5, 0, 2);
        run(32'h002081B3, 0, 0, 0, -1);
        for (int n = 0; n < 200; n++)
            run(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rb(), -1);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got=%0d pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
